// File: rtl/operand_fifo.sv
// Operand-fetch responder: DMA-fed data/weight FIFOs with registered 1-cycle pops and a bias register.
// Optional sticky overflow/underflow flags are enabled by defining OPERAND_FIFO_ERR_FLAG_EN.

module operand_fifo_chan #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = $clog2(DEPTH),
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wr,
    input  logic              rd,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full
`ifdef OPERAND_FIFO_ERR_FLAG_EN
    ,
    output logic              ovf,
    output logic              udf
`endif
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              do_rd;
    logic              do_wr;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    // An empty read is ignored even with a same-cycle write (no bypass); a full
    // write only lands if the same-cycle read frees a slot.
    always_comb begin
        do_rd = 1'b0;
        do_wr = 1'b0;
        if (!flush) begin
            do_rd = rd && !empty;
            do_wr = wr && (!full || do_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= do_rd;
            if (do_wr) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (do_rd) begin
                rd_ptr  <= rd_ptr + ADDR_W'(1);
                rd_data <= mem[rd_ptr];
            end
            if (do_wr && !do_rd) begin
                count <= count + CNT_W'(1);
            end else if (do_rd && !do_wr) begin
                count <= count - CNT_W'(1);
            end
        end
    end

`ifdef OPERAND_FIFO_ERR_FLAG_EN
    // Sticky error flags; flush wins over a same-cycle set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else if (flush) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (wr && !do_wr) begin
                ovf <= 1'b1;
            end
            if (rd && empty) begin
                udf <= 1'b1;
            end
        end
    end
`endif

endmodule

module operand_fifo #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = $clog2(DEPTH),
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [1:0]        wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              flush,
    input  logic              data_fifo_rd_en,
    output logic [DATA_W-1:0] data,
    output logic              data_valid,
    input  logic              weight_fifo_rd_en,
    output logic [DATA_W-1:0] weight,
    output logic              weight_valid,
    output logic [DATA_W-1:0] bias,
    output logic [ADDR_W:0]   data_count,
    output logic [ADDR_W:0]   weight_count,
    output logic              data_empty,
    output logic              data_full,
    output logic              weight_empty,
    output logic              weight_full
`ifdef OPERAND_FIFO_ERR_FLAG_EN
    ,
    output logic              data_ovf,
    output logic              data_udf,
    output logic              weight_ovf,
    output logic              weight_udf
`endif
);

    localparam logic [1:0] SEL_DATA   = 2'd0;
    localparam logic [1:0] SEL_WEIGHT = 2'd1;
    localparam logic [1:0] SEL_BIAS   = 2'd2;

    logic wr_data_fifo;
    logic wr_weight_fifo;

    assign wr_data_fifo   = wr_en && (wr_sel == SEL_DATA);
    assign wr_weight_fifo = wr_en && (wr_sel == SEL_WEIGHT);

    operand_fifo_chan #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_data (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .wr       (wr_data_fifo),
        .rd       (data_fifo_rd_en),
        .wr_data  (wr_data),
        .rd_data  (data),
        .rd_valid (data_valid),
        .count    (data_count),
        .empty    (data_empty),
        .full     (data_full)
`ifdef OPERAND_FIFO_ERR_FLAG_EN
        ,
        .ovf      (data_ovf),
        .udf      (data_udf)
`endif
    );

    operand_fifo_chan #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_weight (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .wr       (wr_weight_fifo),
        .rd       (weight_fifo_rd_en),
        .wr_data  (wr_data),
        .rd_data  (weight),
        .rd_valid (weight_valid),
        .count    (weight_count),
        .empty    (weight_empty),
        .full     (weight_full)
`ifdef OPERAND_FIFO_ERR_FLAG_EN
        ,
        .ovf      (weight_ovf),
        .udf      (weight_udf)
`endif
    );

    // Bias is not a FIFO, so flush leaves it alone and a same-cycle load still lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bias <= '0;
        end else if (wr_en && (wr_sel == SEL_BIAS)) begin
            bias <= wr_data;
        end
    end

endmodule

// File: doc/operand_fifo.md
Name: operand_fifo

Overview:
- Responder side of the engine's operand-fetch interface.
- The DMA pushes fp16 words (data, weight, bias) in through one write port.
- The engine pops data and weight words through independent rd_en strobes; each read returns a registered word one cycle later.
- Two instances sit between the DMA and the engine, one per engine port (p0, p1).

Parameters:
- DEPTH, 256, entries per FIFO (data and weight); must be a power of 2, minimum 4.
- ADDR_W, 8, log2(DEPTH); pointer width.
- DATA_W, 16, word width (fp16).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- wr_en  in  1  DMA write strobe
- wr_sel  in  2  write target: 0 = data FIFO, 1 = weight FIFO, 2 = bias register, 3 = ignored
- wr_data  in  DATA_W  DMA write word
- flush  in  1  synchronous clear of both FIFOs
- data_fifo_rd_en  in  1  engine pop, data FIFO
- data  out  DATA_W  data word, registered
- data_valid  out  1  one-cycle pulse: data updated this cycle
- weight_fifo_rd_en  in  1  engine pop, weight FIFO
- weight  out  DATA_W  weight word, registered
- weight_valid  out  1  one-cycle pulse: weight updated this cycle
- bias  out  DATA_W  current bias register
- data_count  out  ADDR_W+1  data FIFO occupancy, 0..DEPTH
- weight_count  out  ADDR_W+1  weight FIFO occupancy, 0..DEPTH
- data_empty, data_full  out  1 each  combinational from data_count
- weight_empty, weight_full  out  1 each  combinational from weight_count

Behaviour:
- Reset (async, rst=1): all pointers, counts, data, weight, bias and valids = 0. Memory contents are don't-care.
- Each FIFO is a circular buffer with wr_ptr/rd_ptr of ADDR_W bits; pointers wrap DEPTH-1 -> 0 naturally.
- count is a separate ADDR_W+1 register, so full (count==DEPTH) is distinguishable from empty.
- Write:
  - wr_en=1 with wr_sel=0 or 1 writes the selected FIFO at the rising edge: mem[wr_ptr]<=wr_data, wr_ptr+1, count+1.
  - wr_sel=2 loads bias (visible the next cycle).
  - wr_sel=3 has no effect.
- Read:
  - rd_en=1 while not empty: at edge N, out<=mem[rd_ptr], rd_ptr+1, count-1, valid=1 during cycle N+1. Latency is exactly 1.
  - rd_en=0: valid=0 next cycle; out holds its last value.
- Empty read: rd_en while count==0 is ignored. Pointers and out unchanged, valid=0.
- Full write: a write to a FIFO with count==DEPTH and no same-cycle read is dropped. Pointers, count and memory unchanged.
- Simultaneous read and write on the same FIFO:
  - Neither empty nor full: both proceed, count unchanged.
  - Full: both proceed (the write occupies the freed slot), count stays DEPTH.
  - Empty: the write proceeds; the read is ignored (no bypass), valid=0, count becomes 1.
- Flush:
  - Clears both FIFOs' pointers and counts, and data_valid/weight_valid, at the edge.
  - Overrides any same-cycle write or read to the FIFOs.
  - Does not clear bias, data or weight outputs; a same-cycle wr_sel=2 still loads bias.
- Data and weight FIFOs are fully independent; there is no cross-coupling of counts or strobes.
- Reset asserted mid-stream: everything returns to reset values immediately. After deassertion, count=0 and a read is treated as an empty read.

Optional Feature:
- Macro: OPERAND_FIFO_ERR_FLAG_EN.
- Defined: adds outputs data_ovf, data_udf, weight_ovf, weight_udf (1 bit each).
  - Sticky flags: *_ovf sets on a dropped full write; *_udf sets on an ignored empty read.
  - Cleared only by rst or flush. Flush has priority over a same-cycle set.
- Undefined: these ports and their logic are absent. Drop/ignore behaviour is identical in both builds.

Test Plan:
- Write 16 data words 0x3C00 and 16 weight words 0x4000, then assert both rd_en for 16 cycles.
  - data_valid and weight_valid rise 1 cycle after the first rd_en and stay high 16 cycles.
  - Outputs read 0x3C00 and 0x4000; counts step 16 -> 0; empty=1 at end.
- Fill data FIFO with 256 words 0..255, then write 0xFFFF.
  - data_full=1, data_count=256, the write is dropped.
  - Reading all 256 returns 0..255 in order (pointer wrap checked); data_ovf=1 when the macro is defined.
- At data_count=256, assert wr_en(sel=0, 0x4880) and data_fifo_rd_en together.
  - count stays 256; data=word0 next cycle; 0x4880 is read last.
- Empty FIFO, assert rd_en and write 0x4500 in the same cycle.
  - valid=0, count=1; the next rd_en returns 0x4500 one cycle later; an empty read sets data_udf.
- Load 9 words, read 3, pulse flush together with wr_sel=2 (0x4200).
  - counts=0, empty=1, bias=0x4200, data holds its last word; flags cleared.
- Mid-stream with count=5, pulse rst for 3 ns, then rd_en.
  - All outputs go to 0 asynchronously; the subsequent read gives valid=0.
